// File: rtl/word_deserializer_if.sv
// Serial-in / parallel-out bundle for word_deserializer: the word stream
// toward the collector and the assembled vector with its framing flag back out.
interface word_deserializer_if #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 32
);
  logic signed [WIDTH-1:0] s_data;
  logic                    s_valid;
  logic                    s_last;
  logic                    s_ready;
  logic signed [WIDTH-1:0] p_data [SIZE];
  logic                    p_valid;
  logic                    p_ready;
  logic                    err_len;

  // master produces the word stream and consumes vectors; slave is the collector
  modport master (
    output s_data, s_valid, s_last, p_ready,
    input  s_ready, p_data, p_valid, err_len
  );

  modport slave (
    input  s_data, s_valid, s_last, p_ready,
    output s_ready, p_data, p_valid, err_len
  );
endinterface

// File: rtl/word_deserializer.sv
// Collects SIZE consecutive signed words into one parallel vector, checking
// framing against the last-word marker and flagging errors with a one-cycle pulse.
module word_deserializer #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  word_deserializer_if.slave  bus
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_nxt;
  logic                    r_err;
  logic                    w_err_nxt;
  logic signed [WIDTH-1:0] r_data [SIZE];

  logic w_ready;
  logic w_accept;
  logic w_xfer;
  logic w_last_slot;

  // Only a waiting complete vector stalls the stream; a transfer frees the slot on the same edge.
  assign w_ready     = rst_n && ((r_state == FILL) || bus.p_ready);
  assign w_accept    = bus.s_valid && w_ready;
  assign w_xfer      = (r_state == HOLD) && bus.p_ready;
  assign w_last_slot = (r_cnt == CW'(SIZE - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    if (w_xfer) begin
      w_state_nxt = FILL;
    end
    if (w_accept) begin
      if (w_last_slot) begin
        // A full vector is delivered even without its marker; the missing marker is still reported.
        w_state_nxt = HOLD;
        w_cnt_nxt   = '0;
        w_err_nxt   = !bus.s_last;
      end else if (bus.s_last) begin
        w_cnt_nxt = '0;
        w_err_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) begin
        r_data[i] <= '0;
      end
    end else if (w_accept) begin
      r_data[r_cnt] <= bus.s_data;
    end
  end

  assign bus.s_ready = w_ready;
  assign bus.p_valid = (r_state == HOLD);
  assign bus.err_len = r_err;
  assign bus.p_data  = r_data;

endmodule

// File: doc/word_deserializer.md
# word_deserializer

Word-serial to vector collector for the inference datapath: accepts a stream of signed WIDTH-bit words over a valid/ready handshake and assembles SIZE consecutive words into one parallel vector. It is the receive-side counterpart of the parallel-load/shift-out register that emits vectors word by word, lowest index first. It sits between a layer's serial result stream and the next stage's parallel input, and detects framing errors using a last-word marker.

## Interface
- WIDTH, 16, bit width of each signed data word
- SIZE, 32, words per vector; SIZE >= 1
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- s_data  input  signed [WIDTH-1:0]  incoming word
- s_valid  input  1  s_data valid
- s_last  input  1  marks the final word of a vector; qualified by s_valid
- s_ready  output  1  block can accept a word this cycle
- p_data  output  signed [WIDTH-1:0] x [SIZE-1:0]  assembled vector; element 0 = first word received
- p_valid  output  1  p_data holds a complete vector
- p_ready  input  1  consumer takes p_data this cycle
- err_len  output  1  one-cycle pulse on a framing error

## Operation
- Accept = s_valid && s_ready at a rising edge. Transfer = p_valid && p_ready at a rising edge.
- Internal write index cnt, width $clog2(SIZE) (min 1), range 0..SIZE-1.
- On accept: p_data[cnt] <= s_data, then:
  - cnt < SIZE-1 and s_last = 0: cnt increments.
  - cnt < SIZE-1 and s_last = 1 (early last): partial vector discarded, cnt <= 0, p_valid stays 0, err_len pulses.
  - cnt = SIZE-1: vector complete, p_valid <= 1, cnt <= 0. If s_last = 0 (missing last), the vector is still delivered and err_len pulses.
- s_ready = rst_n && (!p_valid || p_ready). Back-pressure is applied only while a complete vector waits.
- On transfer without a completing accept on the same edge: p_valid <= 0.
- On a transfer coinciding with an accept: the old vector is consumed, and the new word is written to p_data[cnt] on the same edge. p_valid remains 1 only if that accept completes a new vector (SIZE = 1 case).
- p_data elements are written in place. While p_valid = 0, p_data shows partial contents and is meaningful only when p_valid = 1.
- p_data is stable while p_valid = 1 and p_ready = 0.
- States:
  - FILL (p_valid = 0): accepting words.
  - HOLD (p_valid = 1): waiting for a transfer. It overlaps with FILL of the next vector on the transfer edge.

## Timing
- Reset (rst_n low, asynchronous): p_data all elements 0, p_valid 0, err_len 0, cnt 0, s_ready 0.
- Reset asserted mid-vector: partial data is lost, and cnt restarts at 0 after release.
- First accept is possible on the first rising edge after rst_n deasserts.
- Latency: p_valid rises immediately after the edge that accepts word SIZE-1. That is SIZE accept edges from the first word, with no extra pipeline cycle.
- Throughput: one word per cycle sustained when p_ready is held high. There is no bubble between vectors: the word-0 accept and the previous vector's transfer share an edge.
- err_len is registered. It is high for exactly the one cycle after the offending accept edge, including when that accept also completes a vector.
- s_valid without s_ready: the word is not taken, and cnt and p_data are unchanged.

## Test plan
- Reset check (WIDTH=16, SIZE=4): with rst_n low, p_valid=0, err_len=0, s_ready=0, and all p_data=0. Release reset, send 1,-2,3,-4 with last on -4 and p_ready=0. Required: p_valid=1 after the 4th accept edge, p_data[0..3]=1,-2,3,-4, and s_ready=0.
- Back-pressure: hold p_ready=0 for 5 cycles with s_valid=1. Required: no words accepted, p_data stable, and no err_len. Then raise p_ready with word 10 present. Required: transfer and accept on the same edge, p_valid=0 the next cycle, and p_data[0]=10.
- Streaming: continuous s_valid, p_ready=1, 12 words 0..11 with last on 3, 7, 11. Required: 3 vectors [0..3], [4..7], [8..11] with p_valid pulsing every 4th cycle, and s_ready constantly 1.
- Early last: send 5,6 with last on 6, then 7,8,9,10 with last on 10. Required: err_len pulses once after the accept of 6, no vector is emitted for 5,6, and the next vector is 7,8,9,10.
- Missing last: send 1,2,3,4 with s_last=0 throughout. Required: vector 1,2,3,4 delivered and err_len high for one cycle in the same cycle p_valid rises.
- Reset mid-vector: accept 2 words, pulse rst_n low between edges. Required: immediate p_valid=0 and p_data=0, then a following 4-word vector assembles starting at index 0.
